// File: rtl/hls_ap_pkg.sv
// Shared definitions for the HLS ap_ctrl_hs call master.
//   hls_ap_state_t : call sequencer states
//   HLS_AP_DWIDTH  : default argument / return width
//   HLS_AP_ERRW    : width of the timeout error counter
//   hls_ap_sat_inc : saturating increment for the error counter
package hls_ap_pkg;

    localparam int HLS_AP_DWIDTH = 32;
    localparam int HLS_AP_ERRW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD_RSP  = 2'd3
    } hls_ap_state_t;

    function automatic logic [HLS_AP_ERRW-1:0] hls_ap_sat_inc(input logic [HLS_AP_ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hls_ap_timeout.sv
// Call watchdog counter.
//   clk_i     : clock (rising edge)
//   rst_i     : synchronous active-high reset
//   clear_i   : restart the count from zero (priority over enable)
//   enable_i  : count one cycle of an outstanding call
//   expired_o : count has reached TIMEOUT-1, i.e. this is the last allowed cycle
module hls_ap_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int          CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/hls_ap_master.sv
// Caller-side master for an HLS block-level ap_ctrl_hs callee.
// Accepts one argument on a valid/ready request port, runs one callee invocation
// (ap_start / ap_ready / ap_done) and holds the return value on a valid/ready
// response port. Calls that exceed TIMEOUT cycles are aborted with rsp_timeout.
//   ap_clk, ap_rst         : clock, synchronous active-high reset
//   req_valid/ready/data   : argument input handshake
//   ctl_start/arg          : callee ap_start and scalar argument
//   ctl_ready/done/idle    : callee ap_ready, ap_done, ap_idle (idle is status only)
//   ctl_return             : callee ap_return
//   rsp_valid/ready/data   : result output handshake, rsp_timeout qualifies it
//   busy                   : any state other than IDLE
//   err_count              : saturating number of timed-out calls
module hls_ap_master
    import hls_ap_pkg::*;
#(
    parameter int DWIDTH  = HLS_AP_DWIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DWIDTH-1:0]      req_data,
    output logic                   ctl_start,
    output logic [DWIDTH-1:0]      ctl_arg,
    input  logic                   ctl_ready,
    input  logic                   ctl_done,
    input  logic                   ctl_idle,
    input  logic [DWIDTH-1:0]      ctl_return,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [HLS_AP_ERRW-1:0] err_count
);

    hls_ap_state_t         state_q, state_d;
    logic [DWIDTH-1:0]     arg_q, arg_d;
    logic [DWIDTH-1:0]     data_q, data_d;
    logic                  tmo_q, tmo_d;
    logic [HLS_AP_ERRW-1:0] err_q, err_d;
    logic                  accept;
    logic                  expired;

    // ap_idle carries no control meaning for the sequencer.
    logic unused_ctl_idle;
    assign unused_ctl_idle = ctl_idle;

    assign accept = (state_q == ST_IDLE) && req_valid;

    hls_ap_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (ap_clk),
        .rst_i     (ap_rst),
        .clear_i   (accept),
        .enable_i  ((state_q == ST_START) || (state_q == ST_WAIT_DONE)),
        .expired_o (expired)
    );

    // NOTE: every next-state variable is defaulted to its current value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    arg_d   = req_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Done only counts together with ready here; a done arriving in the
                // last allowed cycle still beats the timeout.
                if (ctl_ready && ctl_done) begin
                    data_d  = ctl_return;
                    tmo_d   = 1'b0;
                    state_d = ST_HOLD_RSP;
                end else if (expired) begin
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    err_d   = hls_ap_sat_inc(err_q);
                    state_d = ST_HOLD_RSP;
                end else if (ctl_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (ctl_done) begin
                    data_d  = ctl_return;
                    tmo_d   = 1'b0;
                    state_d = ST_HOLD_RSP;
                end else if (expired) begin
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    err_d   = hls_ap_sat_inc(err_q);
                    state_d = ST_HOLD_RSP;
                end
            end
            ST_HOLD_RSP: begin
                if (rsp_ready) begin
                    tmo_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the argument and result registers are reset along with the control state
    // because their reset value (zero) is visible on ctl_arg and rsp_data.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            arg_q   <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign ctl_start   = (state_q == ST_START);
    assign ctl_arg     = arg_q;
    assign rsp_valid   = (state_q == ST_HOLD_RSP);
    assign rsp_data    = data_q;
    assign rsp_timeout = tmo_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_count   = err_q;

endmodule

// File: tb/tb_hls_ap_master.sv
// Self-checking bench for hls_ap_master with an emulated 4-tap moving-average callee.
module tb_hls_ap_master;

    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          ap_clk;
    logic          ap_rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic          ctl_start;
    logic [DW-1:0] ctl_arg;
    logic          ctl_ready;
    logic          ctl_done;
    logic          ctl_idle;
    logic [DW-1:0] ctl_return;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          busy;
    logic [15:0]   err_count;

    hls_ap_master #(.DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .ctl_start   (ctl_start),
        .ctl_arg     (ctl_arg),
        .ctl_ready   (ctl_ready),
        .ctl_done    (ctl_done),
        .ctl_idle    (ctl_idle),
        .ctl_return  (ctl_return),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .err_count   (err_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    always @(posedge ap_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          tmo;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] model_hist[$];   // arguments of calls that completed normally
    int            err_exp = 0;

    // Result of a completed call: mean of the last four completed arguments
    // (missing history counts as zero), floor division.
    function automatic logic [DW-1:0] model_push(input logic [DW-1:0] a);
        logic [63:0] s;
        model_hist.push_back(a);
        if (model_hist.size() > 4) void'(model_hist.pop_front());
        s = '0;
        foreach (model_hist[i]) s = s + {32'b0, model_hist[i]};
        s = s / 4;
        return s[DW-1:0];
    endfunction

    task automatic expect_call(input logic [DW-1:0] a, input bit nd);
        rsp_t r;
        if (nd) begin
            r.data = '0;
            r.tmo  = 1'b1;
            err_exp++;
        end else begin
            r.data = model_push(a);
            r.tmo  = 1'b0;
        end
        exp_q.push_back(r);
    endtask

    // Monitor: compares on every response handshake.
    initial begin
        forever begin
            rsp_t r;
            @(negedge ap_clk);
            #1;
            if (rsp_valid && rsp_ready && !ap_rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_timeout", rsp_timeout, r.tmo);
                end
            end
        end
    end

    // ---------------- callee emulation ----------------
    // ready arrives in callee cycle cfg_rl (1 = first ctl_start cycle), done in
    // cycle cfg_dl; cfg_nd suppresses done entirely.
    int            cfg_rl = 1;
    int            cfg_dl = 1;
    bit            cfg_nd = 1'b0;
    bit            in_call = 1'b0;
    int            ccyc = 0;
    logic [DW-1:0] c_arg;
    logic [DW-1:0] tap [4];

    initial begin
        logic [63:0] s;
        ctl_ready  = 1'b0;
        ctl_done   = 1'b0;
        ctl_return = '0;
        ctl_idle   = 1'b1;
        c_arg      = '0;
        for (int i = 0; i < 4; i++) tap[i] = '0;
        forever begin
            @(negedge ap_clk);
            ctl_idle = 1'($urandom_range(0, 1));
            if (in_call) begin
                ccyc++;
                if (!busy || rsp_valid || ccyc > cfg_dl) in_call = 1'b0;
            end
            if (!in_call && ctl_start) begin
                in_call = 1'b1;
                ccyc    = 1;
                c_arg   = ctl_arg;
            end
            ctl_ready = in_call && ctl_start && (ccyc == cfg_rl);
            ctl_done  = in_call && !cfg_nd && (ccyc == cfg_dl);
            if (ctl_done) begin
                tap[3] = tap[2];
                tap[2] = tap[1];
                tap[1] = tap[0];
                tap[0] = c_arg;
                s = {32'b0, tap[0]} + {32'b0, tap[1]} + {32'b0, tap[2]} + {32'b0, tap[3]};
                ctl_return = s[33:2];
            end else begin
                ctl_return = $urandom;   // junk outside the done cycle
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_call(input logic [DW-1:0] arg, input int rl, input int dl, input bit nd,
                           input int hold, output int lat, output int starts, output logic [DW-1:0] got);
        logic [DW-1:0] held;
        int            guard;
        int            bad;
        cfg_rl = rl;
        cfg_dl = nd ? 1000 : dl;
        cfg_nd = nd;
        req_valid = 1'b1;
        req_data  = arg;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!req_ready) check("accept_wait_expired", 0, 1);
        expect_call(arg, nd);
        @(negedge ap_clk);
        req_valid = 1'b0;
        req_data  = $urandom;
        lat = 1;
        starts = 0;
        bad = 0;
        while (!rsp_valid && lat < 40) begin
            starts += int'(ctl_start);
            if (ctl_arg !== arg || !busy || req_ready) bad++;
            @(negedge ap_clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_wait_expired", 0, 1);
        check("call_arg_flags", bad, 0);
        got = rsp_data;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            held = rsp_data;
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;
                req_data  = $urandom;
                @(negedge ap_clk);
                check("hold_data", rsp_data, held);
                check("hold_flags", {rsp_valid, req_ready, ctl_arg == arg}, 3'b101);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge ap_clk);
        check("idle_after_rsp", {req_ready, busy, rsp_valid, rsp_timeout}, 4'b1000);
        check("err_count", err_count, err_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            st;
        int            prev;
        int            stamp;
        int            guard;
        int            vcnt;
        logic [DW-1:0] got;
        bit            nd;
        int            rl;
        int            dl;

        ap_rst    = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        check("rst_flags", {req_ready, busy, ctl_start, rsp_valid, rsp_timeout}, 5'b10000);
        check("rst_err", err_count, 0);
        check("rst_data", {rsp_data, ctl_arg}, 64'h0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_release_ready", req_ready, 1);

        // Zero-latency callee.
        do_call(32'h10, 1, 1, 1'b0, 0, lat, st, got);
        check("zl_latency", lat, 2);
        check("zl_starts", st, 1);
        check("zl_data", got, 32'h4);

        // Ready at callee cycle 2, done at cycle 5.
        do_call(32'hDEADBEEF, 2, 5, 1'b0, 0, lat, st, got);
        check("wait_starts", st, 2);
        check("wait_latency", lat, 6);

        // Timeouts: once via WAIT_DONE, once never leaving START.
        do_call($urandom, 2, 0, 1'b1, 0, lat, st, got);
        check("tmo1_latency", lat, TMO + 1);
        check("tmo1_data", got, 0);
        do_call($urandom, 0, 0, 1'b1, 0, lat, st, got);
        check("tmo2_starts", st, TMO);
        check("tmo2_err", err_count, 2);

        // Done in the very last allowed cycle wins over the timeout.
        do_call($urandom, 2, TMO, 1'b0, 0, lat, st, got);
        check("done_at_limit_latency", lat, TMO + 1);

        // Stalled response for five cycles.
        do_call($urandom, 1, 1, 1'b0, 5, lat, st, got);

        // Randomised calls.
        for (int i = 0; i < 14; i++) begin
            nd = ($urandom_range(0, 4) == 0);
            rl = nd ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 4));
            dl = int'($urandom_range(rl < 1 ? 1 : rl, TMO));
            do_call($urandom, rl, dl, nd, int'($urandom_range(0, 2)), lat, st, got);
            check("rand_latency", lat, nd ? TMO + 1 : dl + 1);
        end

        // Eight back-to-back calls against a zero-latency callee.
        cfg_rl = 1;
        cfg_dl = 1;
        cfg_nd = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            req_data = $urandom;
            guard = 0;
            while (!req_ready && guard < 20) begin
                @(negedge ap_clk);
                guard++;
            end
            stamp = cyc_cnt;
            expect_call(req_data, 1'b0);
            if (i > 0) check("b2b_period", stamp - prev, 3);
            prev = stamp;
            @(negedge ap_clk);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge ap_clk);

        // Reset pulsed while waiting for done.
        cfg_rl = 2;
        cfg_dl = 5;
        cfg_nd = 1'b0;
        req_valid = 1'b1;
        req_data  = $urandom;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        @(negedge ap_clk);
        req_valid = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("pre_rst_wait", {busy, ctl_start, rsp_valid}, 3'b100);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        check("midrst_flags", {ctl_start, busy, rsp_valid, rsp_timeout, req_ready}, 5'b00001);
        check("midrst_data", {rsp_data, ctl_arg}, 64'h0);
        check("midrst_err", err_count, 0);
        err_exp = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("post_rst_ready", req_ready, 1);
        vcnt = 0;
        repeat (6) begin
            @(negedge ap_clk);
            vcnt += int'(rsp_valid);
        end
        check("post_rst_no_rsp", vcnt, 0);
        do_call($urandom, 1, 3, 1'b0, 0, lat, st, got);
        check("post_rst_latency", lat, 4);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hls_ap_master.md
HLS_AP_MASTER -- requirements
Module: hls_ap_master

Interface
REQ-001 Parameter DWIDTH, default 32: width of call argument and return value.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles from ctl_start assertion to ctl_done; must be at least 2.
REQ-003 Port ap_clk, input, 1: sole clock; all logic rising-edge.
REQ-004 Port ap_rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, 1: caller presents an argument.
REQ-006 Port req_ready, output, 1: block accepts an argument this cycle.
REQ-007 Port req_data, input, DWIDTH: call argument.
REQ-008 Port ctl_start, output, 1: drives callee ap_start.
REQ-009 Port ctl_arg, output, DWIDTH: drives callee scalar argument input.
REQ-010 Port ctl_ready, input, 1: callee ap_ready.
REQ-011 Port ctl_done, input, 1: callee ap_done.
REQ-012 Port ctl_idle, input, 1: callee ap_idle; status only.
REQ-013 Port ctl_return, input, DWIDTH: callee ap_return.
REQ-014 Port rsp_valid, output, 1: result held for the caller.
REQ-015 Port rsp_ready, input, 1: caller consumes the result.
REQ-016 Port rsp_data, output, DWIDTH: captured return value.
REQ-017 Port rsp_timeout, output, 1: qualifies rsp_valid; call aborted on timeout.
REQ-018 Port busy, output, 1: high in every state except IDLE.
REQ-019 Port err_count, output, 16: saturating count of timeouts.

Function
REQ-020 The FSM SHALL have the states IDLE, START, WAIT_DONE and HOLD_RSP.
REQ-021 In IDLE, req_ready SHALL be 1; a transfer (req_valid && req_ready) SHALL latch req_data into ctl_arg and move to START on the next edge.
REQ-022 req_ready SHALL be 0 in all states other than IDLE.
REQ-023 ctl_start SHALL be 1 exactly while in START; ctl_arg SHALL stay stable from acceptance until the next accepted request.
REQ-024 In START with ctl_ready=1 and ctl_done=1 in the same cycle, the block SHALL capture ctl_return into rsp_data and go to HOLD_RSP (zero-latency callee).
REQ-025 In START with ctl_ready=1 and ctl_done=0, the block SHALL go to WAIT_DONE; ctl_start SHALL be low from the next cycle.
REQ-026 In WAIT_DONE, ctl_done=1 SHALL capture ctl_return and move to HOLD_RSP; ctl_ready in WAIT_DONE SHALL be ignored.
REQ-027 A cycle counter SHALL clear on entry to START and increment in each cycle spent in START or WAIT_DONE.
REQ-028 If the counter reaches TIMEOUT-1 without ctl_done, the block SHALL go to HOLD_RSP with rsp_data=0 and rsp_timeout=1, and increment err_count (saturating at 0xFFFF).
REQ-029 ctl_done in the timeout cycle SHALL win: a normal capture, no timeout.
REQ-030 In HOLD_RSP, rsp_valid SHALL be 1 with rsp_data and rsp_timeout stable until rsp_ready=1; then IDLE next edge, with rsp_valid and rsp_timeout cleared.
REQ-031 Minimum call period SHALL be 3 cycles (IDLE, START, HOLD_RSP, each with an immediate handshake).
REQ-032 ctl_idle SHALL NOT affect any state transition.

Reset
REQ-033 With ap_rst=1 at an edge, state SHALL become IDLE and rsp_valid, rsp_timeout, ctl_start, busy, the counter and err_count SHALL become 0; rsp_data and ctl_arg SHALL become 0.
REQ-034 Reset asserted mid-call SHALL drop ctl_start at that edge and discard any pending result; req_ready SHALL be 1 in the first cycle after reset releases.

Structure
REQ-035 Package hls_ap_pkg SHALL hold the state enum typedef hls_ap_state_t and the constants HLS_AP_DWIDTH=32 and HLS_AP_ERRW=16.
REQ-036 The timeout counter SHALL be a sub-module hls_ap_timeout (clear, enable, expired), parameterised by TIMEOUT.

Verification
REQ-037 Zero-latency callee (ctl_ready=ctl_done=ctl_start), req_data=0x10 with ctl_return=0x04 -> rsp_valid 2 cycles after acceptance, rsp_data=0x00000004, rsp_timeout=0.
REQ-038 Callee with ctl_ready at cycle 2 and ctl_done at cycle 5 after start, req_data=0xDEADBEEF -> ctl_start high exactly 2 cycles, ctl_arg=0xDEADBEEF throughout, rsp_data captured at the done cycle.
REQ-039 TIMEOUT=8, ctl_done never asserted -> rsp_valid with rsp_timeout=1, rsp_data=0, err_count=1; a second call -> err_count=2.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready=0, req_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-041 ap_rst pulsed in WAIT_DONE -> all outputs 0 at that edge, no rsp_valid afterwards, next call completes normally.
REQ-042 Eight back-to-back calls with random data against a 4-tap moving-average model -> every rsp_data equals the model output, period 3 cycles each.
